// File: rtl/sd_block_responder_if.sv
// Block-device handshake between the core's sector buffer, the responder and the image RAM.
// slave = responder side; master = core/harness side.
interface sd_block_responder_if #(
  parameter int unsigned IMG_AW = 24
);
  logic [31:0]     sd_lba;
  logic            sd_rd;
  logic            sd_wr;
  logic            sd_ack;
  logic [8:0]      sd_buff_addr;
  logic [7:0]      sd_buff_dout;
  logic [7:0]      sd_buff_din;
  logic            sd_buff_wr;
  logic [IMG_AW:0] img_size;
  logic            img_readonly;
  logic [IMG_AW-1:0] img_addr;
  logic            img_rd;
  logic [7:0]      img_din;
  logic            img_wr;
  logic [7:0]      img_dout;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_size, img_readonly, img_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, img_addr, img_rd, img_wr, img_dout
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, img_size, img_readonly, img_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, img_addr, img_rd, img_wr, img_dout
  );
endinterface

// File: rtl/sd_block_responder.sv
// Host-side block server model: services one 512-byte sector read or write per request
// against a byte-wide image memory, two cycles per byte.
module sd_block_responder #(
  parameter int unsigned IMG_AW    = 24,
  parameter int unsigned ACK_DELAY = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  sd_block_responder_if.slave   bus
);

  localparam int unsigned IDX_W  = 10;
  localparam int unsigned DLY_W  = 8;
  localparam int unsigned END_W  = (IMG_AW + 1 > 42) ? IMG_AW + 1 : 42;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(511);
  localparam logic [IDX_W-1:0] IDX_TRAIL = IDX_W'(512);

  typedef enum logic [2:0] {IDLE, DELAY, XFER_RD, XFER_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              phase_q, phase_d;
  logic [31:0]       lba_q, lba_d;
  logic              dir_rd_q, dir_rd_d;
  logic              ack_q, ack_d;
  logic [IMG_AW-1:0] img_addr_q, img_addr_d;
  logic              img_rd_q, img_rd_d;
  logic              img_wr_q, img_wr_d;
  logic [8:0]        buff_addr_q, buff_addr_d;
  logic              buff_wr_q, buff_wr_d;
  logic              dout_en_q, dout_en_d;

  // Range test at full width so a huge lba cannot wrap back into the image
  logic [END_W-1:0]  sec_end;
  logic              in_range;
  logic [IMG_AW-1:0] base;
  logic [IDX_W-1:0]  idx_nxt;
  logic [IMG_AW-1:0] addr_cur;
  logic [IMG_AW-1:0] addr_nxt;

  assign sec_end  = END_W'({33'(lba_q) + 33'd1, 9'd0});
  assign in_range = sec_end <= END_W'(bus.img_size);
  assign base     = IMG_AW'({lba_q, 9'd0});
  assign idx_nxt  = idx_q + IDX_W'(1);
  assign addr_cur = base + IMG_AW'(idx_q);
  assign addr_nxt = base + IMG_AW'(idx_nxt);

  // Next-state and next-output logic; outputs describe the following cycle
  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    lba_d       = lba_q;
    dir_rd_d    = dir_rd_q;
    ack_d       = ack_q;
    img_addr_d  = img_addr_q;
    buff_addr_d = buff_addr_q;
    img_rd_d    = 1'b0;
    img_wr_d    = 1'b0;
    buff_wr_d   = 1'b0;
    dout_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (bus.sd_rd || bus.sd_wr) begin
          lba_d    = bus.sd_lba;
          dir_rd_d = bus.sd_rd;
          dly_d    = DLY_W'(ACK_DELAY);
          state_d  = DELAY;
        end
      end

      DELAY: begin
        if (dly_q == '0) begin
          ack_d   = 1'b1;
          idx_d   = '0;
          phase_d = 1'b0;
          if (dir_rd_q) begin
            state_d    = XFER_RD;
            img_addr_d = base;
            img_rd_d   = in_range;
          end else begin
            state_d     = XFER_WR;
            buff_addr_d = 9'd0;
          end
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end

      XFER_RD, XFER_WR: begin
        if (idx_q == IDX_TRAIL) begin
          ack_d   = 1'b0;
          idx_d   = '0;
          state_d = DONE;
        end else if (!phase_q) begin
          phase_d = 1'b1;
          if (state_q == XFER_RD) begin
            buff_addr_d = 9'(idx_q);
            buff_wr_d   = 1'b1;
            dout_en_d   = in_range;
          end else begin
            img_addr_d = addr_cur;
            img_wr_d   = in_range && !bus.img_readonly;
          end
        end else begin
          phase_d = 1'b0;
          idx_d   = idx_nxt;
          // Byte 511 is followed by one strobe-free trailing cycle
          if (idx_q != IDX_LAST) begin
            if (state_q == XFER_RD) begin
              img_addr_d = addr_nxt;
              img_rd_d   = in_range;
            end else begin
              buff_addr_d = 9'(idx_nxt);
            end
          end
        end
      end

      DONE: begin
        ack_d = 1'b0;
        if (!bus.sd_rd && !bus.sd_wr) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      dly_q       <= '0;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      lba_q       <= '0;
      dir_rd_q    <= 1'b0;
      ack_q       <= 1'b0;
      img_addr_q  <= '0;
      img_rd_q    <= 1'b0;
      img_wr_q    <= 1'b0;
      buff_addr_q <= '0;
      buff_wr_q   <= 1'b0;
      dout_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      lba_q       <= lba_d;
      dir_rd_q    <= dir_rd_d;
      ack_q       <= ack_d;
      img_addr_q  <= img_addr_d;
      img_rd_q    <= img_rd_d;
      img_wr_q    <= img_wr_d;
      buff_addr_q <= buff_addr_d;
      buff_wr_q   <= buff_wr_d;
      dout_en_q   <= dout_en_d;
    end
  end

  // Data paths pass through in the strobe cycle, gated by registered enables
  assign bus.sd_ack       = ack_q;
  assign bus.img_addr     = img_addr_q;
  assign bus.img_rd       = img_rd_q;
  assign bus.img_wr       = img_wr_q;
  assign bus.sd_buff_addr = buff_addr_q;
  assign bus.sd_buff_wr   = buff_wr_q;
  assign bus.sd_buff_dout = dout_en_q ? bus.img_din : 8'h00;
  assign bus.img_dout     = img_wr_q ? bus.sd_buff_din : 8'h00;

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: image byte k = k[7:0], core buffer byte j = ~j[7:0].
module tb_sd_block_responder;

  localparam int unsigned IMG_AW    = 24;
  localparam int unsigned ACK_DELAY = 4;

  logic clk_sys;
  logic reset;
  int   cyc;

  sd_block_responder_if #(.IMG_AW(IMG_AW)) bus ();

  sd_block_responder #(.IMG_AW(IMG_AW), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Image RAM and core buffer models: one-cycle read latency
  always @(posedge clk_sys) begin
    if (bus.img_rd) bus.img_din <= bus.img_addr[7:0];
    bus.sd_buff_din <= ~bus.sd_buff_addr[7:0];
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction monitor, sampled on the falling edge
  logic [23:0] exp_base = '0;
  bit          exp_zero = 1'b0;
  bit          ack_prev = 1'b0;
  int          rise_cyc, ack_len, n_rd, n_bw, n_iw, errs;
  int          tot_rises, tot_falls, tot_iw, tot_overlap;
  logic [23:0] first_rd, last_rd, first_iw, last_iw;
  logic [7:0]  exp_d;

  always @(negedge clk_sys) begin
    if (bus.sd_ack && !ack_prev) begin
      rise_cyc = cyc; ack_len = 0; n_rd = 0; n_bw = 0; n_iw = 0; errs = 0;
      tot_rises++;
    end
    if (!bus.sd_ack && ack_prev) tot_falls++;
    ack_prev = bus.sd_ack;
    if (bus.sd_ack) ack_len++;
    if (int'(bus.img_rd) + int'(bus.img_wr) + int'(bus.sd_buff_wr) > 1) tot_overlap++;
    if (bus.img_rd) begin
      if (n_rd == 0) first_rd = bus.img_addr;
      last_rd = bus.img_addr;
      if (bus.img_addr != exp_base + 24'(n_rd)) errs++;
      n_rd++;
    end
    if (bus.sd_buff_wr) begin
      exp_d = exp_zero ? 8'h00 : 8'(n_bw);
      if (bus.sd_buff_addr != 9'(n_bw) || bus.sd_buff_dout != exp_d) errs++;
      n_bw++;
    end
    if (bus.img_wr) begin
      if (n_iw == 0) first_iw = bus.img_addr;
      last_iw = bus.img_addr;
      if (bus.img_addr != exp_base + 24'(n_iw) || bus.img_dout != ~8'(n_iw)) errs++;
      n_iw++;
      tot_iw++;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
    #1;
  endtask

  // Drive one request; hold keeps sd_rd/sd_wr asserted afterwards
  task automatic issue(input bit rd, input bit wr, input logic [31:0] lba, input logic [23:0] base,
                       input bit zero, input bit hold, output int drive_cyc, output int falls0);
    @(negedge clk_sys);
    exp_base = base; exp_zero = zero;
    bus.sd_lba = lba; bus.sd_rd = rd; bus.sd_wr = wr;
    drive_cyc = cyc; falls0 = tot_falls;
    @(negedge clk_sys);
    if (!hold) begin bus.sd_rd = 1'b0; bus.sd_wr = 1'b0; end
    bus.sd_lba = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input string tag, input int falls0);
    int n = 0;
    while (tot_falls == falls0 && n < 3000) begin @(negedge clk_sys); #1; n++; end
    check_eq(tag, 64'(tot_falls - falls0), 64'd1);
    idle(3);
  endtask

  int dc, f0, r0, iw0;

  initial begin
    reset = 1'b1;
    bus.sd_lba = '0; bus.sd_rd = 1'b0; bus.sd_wr = 1'b0;
    bus.img_size = 25'h10_0000; bus.img_readonly = 1'b0;
    idle(3);
    check_eq("rst_ack", 64'(bus.sd_ack), 64'd0);
    check_eq("rst_strobes", 64'({bus.img_rd, bus.img_wr, bus.sd_buff_wr}), 64'd0);
    check_eq("rst_img_addr", 64'(bus.img_addr), 64'd0);
    check_eq("rst_buff", 64'({bus.sd_buff_addr, bus.sd_buff_dout, bus.img_dout}), 64'd0);
    reset = 1'b0;
    idle(2);

    // Read, in range, lba 3
    issue(1, 0, 32'd3, 24'h600, 0, 0, dc, f0);
    wait_done("rd_done", f0);
    check_eq("rd_latency", 64'(rise_cyc - dc), 64'(ACK_DELAY + 2));
    check_eq("rd_ack_len", 64'(ack_len), 64'd1025);
    check_eq("rd_n_buffwr", 64'(n_bw), 64'd512);
    check_eq("rd_n_imgrd", 64'(n_rd), 64'd512);
    check_eq("rd_first_addr", 64'(first_rd), 64'h600);
    check_eq("rd_last_addr", 64'(last_rd), 64'h7FF);
    check_eq("rd_errs", 64'(errs), 64'd0);
    check_eq("rd_n_imgwr", 64'(n_iw), 64'd0);

    // Write, lba 1
    issue(0, 1, 32'd1, 24'h200, 0, 0, dc, f0);
    wait_done("wr_done", f0);
    check_eq("wr_ack_len", 64'(ack_len), 64'd1025);
    check_eq("wr_n_imgwr", 64'(n_iw), 64'd512);
    check_eq("wr_first_addr", 64'(first_iw), 64'h200);
    check_eq("wr_last_addr", 64'(last_iw), 64'h3FF);
    check_eq("wr_errs", 64'(errs), 64'd0);
    check_eq("wr_no_reads", 64'(n_rd + n_bw), 64'd0);

    // Read-only write, lba 0
    bus.img_readonly = 1'b1;
    issue(0, 1, 32'd0, 24'h0, 0, 0, dc, f0);
    wait_done("ro_done", f0);
    check_eq("ro_ack_len", 64'(ack_len), 64'd1025);
    check_eq("ro_n_imgwr", 64'(n_iw), 64'd0);
    bus.img_readonly = 1'b0;

    // Range boundaries with a 1 KiB image
    bus.img_size = 25'h400;
    issue(1, 0, 32'd2, 24'h400, 1, 0, dc, f0);
    wait_done("oor_done", f0);
    check_eq("oor_n_imgrd", 64'(n_rd), 64'd0);
    check_eq("oor_n_buffwr", 64'(n_bw), 64'd512);
    check_eq("oor_errs", 64'(errs), 64'd0);
    issue(1, 0, 32'd1, 24'h200, 0, 0, dc, f0);
    wait_done("edge_done", f0);
    check_eq("edge_n_imgrd", 64'(n_rd), 64'd512);
    check_eq("edge_errs", 64'(errs), 64'd0);
    issue(1, 0, 32'hFFFF_FFFF, 24'hFFFE00, 1, 0, dc, f0);
    wait_done("wrap_done", f0);
    check_eq("wrap_n_imgrd", 64'(n_rd), 64'd0);
    check_eq("wrap_errs", 64'(errs), 64'd0);
    bus.img_size = 25'h10_0000;

    // Both request lines high: read wins
    issue(1, 1, 32'd4, 24'h800, 0, 0, dc, f0);
    wait_done("both_done", f0);
    check_eq("both_n_buffwr", 64'(n_bw), 64'd512);
    check_eq("both_n_imgwr", 64'(n_iw), 64'd0);
    check_eq("both_errs", 64'(errs), 64'd0);

    // Held request must not retrigger
    r0 = tot_rises;
    issue(1, 0, 32'd0, 24'h0, 0, 1, dc, f0);
    wait_done("hold_done", f0);
    idle(40);
    check_eq("hold_no_retrigger", 64'(tot_rises - r0), 64'd1);
    bus.sd_rd = 1'b0;
    idle(5);
    check_eq("hold_release_quiet", 64'(tot_rises - r0), 64'd1);
    issue(1, 0, 32'd5, 24'hA00, 0, 0, dc, f0);
    wait_done("after_hold_done", f0);
    check_eq("after_hold_first", 64'(first_rd), 64'hA00);
    check_eq("after_hold_ack_len", 64'(ack_len), 64'd1025);
    check_eq("after_hold_errs", 64'(errs), 64'd0);

    // Reset at byte 100 of a write
    issue(0, 1, 32'd2, 24'h400, 0, 0, dc, f0);
    for (int n = 0; n < 3000 && n_iw < 100; n++) begin @(negedge clk_sys); #1; end
    check_eq("rst_mid_reached", 64'(n_iw), 64'd100);
    reset = 1'b1;
    iw0 = tot_iw;
    idle(1);
    check_eq("rst_mid_ack", 64'(bus.sd_ack), 64'd0);
    idle(2);
    reset = 1'b0;
    idle(20);
    check_eq("rst_mid_no_imgwr", 64'(tot_iw - iw0), 64'd0);
    issue(0, 1, 32'd2, 24'h400, 0, 0, dc, f0);
    wait_done("rst_retry_done", f0);
    check_eq("rst_retry_first", 64'(first_iw), 64'h400);
    check_eq("rst_retry_n_imgwr", 64'(n_iw), 64'd512);
    check_eq("rst_retry_errs", 64'(errs), 64'd0);

    check_eq("strobe_overlap", 64'(tot_overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
